led_pattern_ctrl: RTL
=====================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000: clock cycles per pattern step at speed 0; legal range 8 or greater.
REQ-002 Port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port press, input, 4: one-cycle press pulses, one bit per debounced key; [0] start/pause, [1] pattern, [2] speed, [3] clear.
REQ-005 Port led, output, 4: registered LED drive.
REQ-006 Port run_state, output, 2: registered FSM state; IDLE=0, RUN=1, PAUSE=2.
REQ-007 Port step, output, 1: registered one-cycle pulse, high in the cycle after led advances.

Function
REQ-008 The FSM SHALL have three states: IDLE, RUN and PAUSE; encoding 3 is unreachable and SHALL recover to IDLE on the next edge.
REQ-009 Each cycle, only the highest-priority asserted press bit SHALL be serviced; priority order is [3] > [0] > [1] > [2]; all other asserted bits in that cycle SHALL be dropped.
REQ-010 press[3] SHALL, from any state, set state=IDLE, led=0000, pattern=CHASE, speed=0 and prescaler=0 on the next edge.
REQ-011 press[0] SHALL cause these transitions:
  - IDLE->RUN: led loads the current pattern's initial value and the prescaler clears.
  - RUN->PAUSE: led and prescaler hold.
  - PAUSE->RUN: resumes from the held prescaler count.
REQ-012 press[1] SHALL advance the pattern CHASE->BLINK->COUNT->CHASE in every state.
REQ-013 If press[1] is serviced in RUN or PAUSE, led SHALL load the new pattern's initial value and the prescaler SHALL clear on that edge.
REQ-014 If press[1] is serviced in IDLE, led SHALL remain 0000.
REQ-015 press[2] SHALL increment speed 0..3 with wrap 3->0, and SHALL clear the prescaler.
REQ-016 Step period SHALL be TICK_DIV>>speed cycles; the prescaler counts 0..period-1.
REQ-017 The prescaler SHALL advance only in RUN, and a step occurs on the edge where the prescaler equals period-1, at which point it returns to 0.
REQ-018 The prescaler width SHALL be $clog2(TICK_DIV).
REQ-019 A press bit serviced in the same cycle as a step SHALL take precedence; that step is suppressed and step stays low.
REQ-020 Pattern sequences SHALL be:
  - CHASE: initial 0001; 0001->0010->0100->1000->0001.
  - BLINK: initial 1111; 1111<->0000.
  - COUNT: initial 0000; binary +1, wrapping 1111->0000.
REQ-021 In IDLE, led SHALL be 0000 and step SHALL be 0.
REQ-022 Press-to-output latency SHALL be one clock edge.

Reset
REQ-023 With reset high at an edge, the block SHALL set state=IDLE, led=0000, step=0, pattern=CHASE, speed=0 and prescaler=0.
REQ-024 Reset SHALL override any press bit sampled in the same cycle.
REQ-025 Reset asserted mid-RUN or mid-PAUSE SHALL abort immediately, with no further step pulse.

Structure
REQ-026 The state encoding, pattern encoding, press bit indices and pattern initial values SHALL reside in shared package led_ctrl_pkg.
REQ-027 The prescaler SHALL be sub-module tick_gen.
  - Inputs: clk, reset, en, clr, speed[1:0].
  - Output: tick.
  - Parameter: TICK_DIV.
REQ-028 The pattern update and FSM SHALL stay in led_pattern_ctrl.

Verification (TICK_DIV=8)
REQ-029 Reset, then press[0] -> the next edge gives run_state=1 and led=0001; step pulses every 8 cycles; led follows 0010, 0100, 1000, 0001.
REQ-030 In RUN/CHASE, press[1] twice -> led=1111 on the first edge, then 0000; then COUNT increments each step and wraps 1111->0000 after 16 steps.
REQ-031 In RUN, press[2] three times, then observe -> step period is 1 cycle at speed 3; a fourth press[2] restores the 8-cycle period.
REQ-032 press=4'b1111 in RUN -> only clear is serviced: IDLE, led=0000, CHASE, speed 0; press=4'b0011 in IDLE -> RUN with CHASE, pattern unchanged.
REQ-033 PAUSE at prescaler=5 -> led holds for 20 cycles; resume gives the next step 2 cycles later.
REQ-034 Reset asserted in RUN at prescaler=7, together with press[1] -> led=0000, run_state=0, no step pulse, pattern CHASE.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | led_ctrl_pkg : shared encodings and pattern helpers for LED control |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } run_state_t;

  typedef enum logic [1:0] {
    PAT_CHASE = 2'd0,
    PAT_BLINK = 2'd1,
    PAT_COUNT = 2'd2
  } pattern_t;

  localparam int unsigned KEY_START   = 0;
  localparam int unsigned KEY_PATTERN = 1;
  localparam int unsigned KEY_SPEED   = 2;
  localparam int unsigned KEY_CLEAR   = 3;

  localparam logic [3:0] INIT_CHASE = 4'b0001;
  localparam logic [3:0] INIT_BLINK = 4'b1111;
  localparam logic [3:0] INIT_COUNT = 4'b0000;

  function automatic pattern_t pattern_succ(input pattern_t p);
    case (p)
      PAT_CHASE: return PAT_BLINK;
      PAT_BLINK: return PAT_COUNT;
      default:   return PAT_CHASE;
    endcase
  endfunction

  function automatic logic [3:0] pattern_init(input pattern_t p);
    case (p)
      PAT_CHASE: return INIT_CHASE;
      PAT_BLINK: return INIT_BLINK;
      default:   return INIT_COUNT;
    endcase
  endfunction

  function automatic logic [3:0] led_advance(input pattern_t p, input logic [3:0] cur);
    case (p)
      PAT_CHASE: return {cur[2:0], cur[3]};
      PAT_BLINK: return ~cur;
      default:   return cur + 4'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// +----------------------------------------------------------------------+
// | tick_gen : step prescaler, period TICK_DIV >> speed                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] count;
  logic [CW-1:0] last;

  assign last = CW'((TICK_DIV >> speed) - 1);
  assign tick = en && (count == last);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      // >= keeps the counter bounded even if speed moved without a clear
      if (count >= last) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
// +----------------------------------------------------------------------+
// | led_pattern_ctrl : key-driven LED pattern sequencer (IDLE/RUN/PAUSE) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] press,
  output logic [3:0] led,
  output logic [1:0] run_state,
  output logic       step
);

  run_state_t state, state_nxt;
  pattern_t   pat, pat_nxt;
  logic [1:0] speed, speed_nxt;
  logic [3:0] led_nxt;
  logic       step_nxt;
  logic       tick, tick_en, tick_clr;

  // Any serviced press freezes the prescaler for that edge, so a press always beats a step.
  assign tick_en  = (state == ST_RUN) && (press == 4'b0000);
  assign tick_clr = press[KEY_CLEAR] ||
                    (press[KEY_START] ? (state == ST_IDLE)
                                      : (press[KEY_PATTERN] || press[KEY_SPEED]));

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .speed (speed),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pat   <= PAT_CHASE;
      speed <= 2'd0;
      led   <= 4'b0000;
      step  <= 1'b0;
    end else begin
      state <= state_nxt;
      pat   <= pat_nxt;
      speed <= speed_nxt;
      led   <= led_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    speed_nxt = speed;
    led_nxt   = led;
    step_nxt  = 1'b0;

    if (press[KEY_CLEAR]) begin
      state_nxt = ST_IDLE;
      pat_nxt   = PAT_CHASE;
      speed_nxt = 2'd0;
      led_nxt   = 4'b0000;
    end else if (press[KEY_START]) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_RUN;
          led_nxt   = pattern_init(pat);
        end
        ST_RUN:   state_nxt = ST_PAUSE;
        ST_PAUSE: state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end else if (press[KEY_PATTERN]) begin
      pat_nxt = pattern_succ(pat);
      if (state == ST_RUN || state == ST_PAUSE) led_nxt = pattern_init(pattern_succ(pat));
      else                                      led_nxt = 4'b0000;
    end else if (press[KEY_SPEED]) begin
      speed_nxt = speed + 2'd1;
    end else if (tick) begin
      led_nxt  = led_advance(pat, led);
      step_nxt = 1'b1;
    end

    // The unused encoding falls back to IDLE with the LEDs dark.
    if (state != ST_IDLE && state != ST_RUN && state != ST_PAUSE) begin
      state_nxt = ST_IDLE;
      led_nxt   = 4'b0000;
      step_nxt  = 1'b0;
    end
  end

  assign run_state = state;

endmodule

`default_nettype wire
